// File: rtl/alioth_dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Mask legality helper is used only when DMEM_MISALIGN_CHK_EN is defined.
package alioth_dmem_pkg;

    localparam int unsigned BUS_ADDR_WIDTH = 32;
    localparam int unsigned BUS_DATA_WIDTH = 32;
    localparam int unsigned BUS_MASK_WIDTH = BUS_DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    localparam logic [3:0] MASK_B0 = 4'b0001;
    localparam logic [3:0] MASK_B1 = 4'b0010;
    localparam logic [3:0] MASK_B2 = 4'b0100;
    localparam logic [3:0] MASK_B3 = 4'b1000;
    localparam logic [3:0] MASK_H0 = 4'b0011;
    localparam logic [3:0] MASK_H2 = 4'b1100;
    localparam logic [3:0] MASK_W  = 4'b1111;

    // Captured request payload held from accept until the response.
    typedef struct packed {
        logic                      we;
        logic                      err;
        logic [BUS_DATA_WIDTH-1:0] wdata;
        logic [BUS_MASK_WIDTH-1:0] wmask;
    } dmem_req_t;

    // True when the byte mask is a naturally aligned access for the given address offset.
    function automatic logic dmem_mask_legal(input logic [1:0] addr_lsb, input logic [3:0] mask);
        logic legal;
        legal = 1'b0;
        if (mask == 4'b0000) begin
            legal = 1'b1;
        end else begin
            case (addr_lsb)
                2'd0:    legal = (mask == MASK_B0) || (mask == MASK_H0) || (mask == MASK_W);
                2'd1:    legal = (mask == MASK_B1);
                2'd2:    legal = (mask == MASK_B2) || (mask == MASK_H2);
                default: legal = (mask == MASK_B3);
            endcase
        end
        return legal;
    endfunction

endpackage

// File: rtl/dmem_sram.sv
// Single-port word array with per-byte write enables and registered read data.
// Read data changes only on a read access; writes leave it untouched.
module dmem_sram
    import alioth_dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic                      clk,
    input  logic                      en,
    input  logic                      we,
    input  logic [BUS_MASK_WIDTH-1:0] be,
    input  logic [IDX_W-1:0]          addr,
    input  logic [BUS_DATA_WIDTH-1:0] wdata,
    output logic [BUS_DATA_WIDTH-1:0] rdata
);

    logic [BUS_DATA_WIDTH-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int b = 0; b < int'(BUS_MASK_WIDTH); b++) begin
                    if (be[b]) begin
                        mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                    end
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder: accepts one load/store at a time and answers after WAIT_CYCLES stalls.
// Define DMEM_MISALIGN_CHK_EN to reject store masks that do not match addr[1:0].
module dmem_responder
    import alioth_dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      mem_req_i,
    input  logic                      mem_we_i,
    input  logic [BUS_ADDR_WIDTH-1:0] mem_raddr_i,
    input  logic [BUS_ADDR_WIDTH-1:0] mem_waddr_i,
    input  logic [BUS_DATA_WIDTH-1:0] mem_wdata_i,
    input  logic [BUS_MASK_WIDTH-1:0] mem_wmask_i,
    output logic                      mem_gnt_o,
    output logic                      mem_rvalid_o,
    output logic [BUS_DATA_WIDTH-1:0] mem_rdata_o,
    output logic                      mem_err_o
);

    localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    dmem_state_e state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    dmem_req_t   req_q;
    logic [IDX_W-1:0] idx_q;
    logic        rd_zero_q;
    logic        accept;

    logic [BUS_ADDR_WIDTH-1:0] acc_addr, acc_off;
    logic                      acc_err;
    logic [IDX_W-1:0]          acc_idx;

    logic                      cur_we, cur_err;
    logic [IDX_W-1:0]          cur_idx;
    logic                      sram_rd, sram_wr;
    logic [BUS_DATA_WIDTH-1:0] sram_rdata;

    // Decode of the incoming request address.
    always_comb begin
        acc_addr = mem_we_i ? mem_waddr_i : mem_raddr_i;
        acc_off  = acc_addr - BASE_ADDR;
        acc_idx  = acc_off[IDX_W+1:2];
        acc_err  = (acc_addr < BASE_ADDR) || ((acc_off >> 2) >= BUS_ADDR_WIDTH'(DEPTH_WORDS));
`ifdef DMEM_MISALIGN_CHK_EN
        if (mem_we_i && !dmem_mask_legal(acc_addr[1:0], mem_wmask_i)) begin
            acc_err = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        accept       = 1'b0;
        mem_gnt_o    = 1'b0;
        mem_rvalid_o = 1'b0;
        mem_err_o    = 1'b0;
        case (state_q)
            IDLE: begin
                mem_gnt_o = 1'b1;
                if (mem_req_i) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES > 0) begin
                        state_d = WAIT;
                        cnt_d   = WAIT_LOAD;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                mem_rvalid_o = 1'b1;
                mem_err_o    = req_q.err;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q <= '0;
            idx_q <= '0;
        end else if (accept) begin
            req_q <= '{we: mem_we_i, err: acc_err, wdata: mem_wdata_i, wmask: mem_wmask_i};
            idx_q <= acc_idx;
        end
    end

    // With zero wait states the read is launched in the accept cycle, before capture.
    always_comb begin
        if (state_q == IDLE) begin
            cur_we  = mem_we_i;
            cur_err = acc_err;
            cur_idx = acc_idx;
        end else begin
            cur_we  = req_q.we;
            cur_err = req_q.err;
            cur_idx = idx_q;
        end
        sram_rd = (state_d == RESP) && !cur_we && !cur_err;
        sram_wr = (state_q == RESP) && req_q.we && !req_q.err;
    end

    // Forces rdata to zero after reset and for faulted reads; held until the next read response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_zero_q <= 1'b1;
        end else if ((state_d == RESP) && !cur_we) begin
            rd_zero_q <= cur_err;
        end
    end

    dmem_sram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_sram (
        .clk   (clk),
        .en    (sram_rd | sram_wr),
        .we    (sram_wr),
        .be    (req_q.wmask),
        .addr  (cur_idx),
        .wdata (req_q.wdata),
        .rdata (sram_rdata)
    );

    assign mem_rdata_o = rd_zero_q ? '0 : sram_rdata;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: one responder with no wait states and one with three.
module tb_dmem_responder;

`ifdef DMEM_MISALIGN_CHK_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req    [2];
    logic        we     [2];
    logic [31:0] raddr  [2];
    logic [31:0] waddr  [2];
    logic [31:0] wdata  [2];
    logic [3:0]  wmask  [2];
    logic        gnt    [2];
    logic        rvalid [2];
    logic [31:0] rdata  [2];
    logic        err    [2];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dmem_responder #(.WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .mem_req_i(req[0]), .mem_we_i(we[0]),
        .mem_raddr_i(raddr[0]), .mem_waddr_i(waddr[0]), .mem_wdata_i(wdata[0]),
        .mem_wmask_i(wmask[0]), .mem_gnt_o(gnt[0]), .mem_rvalid_o(rvalid[0]),
        .mem_rdata_o(rdata[0]), .mem_err_o(err[0])
    );

    dmem_responder #(.WAIT_CYCLES(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .mem_req_i(req[1]), .mem_we_i(we[1]),
        .mem_raddr_i(raddr[1]), .mem_waddr_i(waddr[1]), .mem_wdata_i(wdata[1]),
        .mem_wmask_i(wmask[1]), .mem_gnt_o(gnt[1]), .mem_rvalid_o(rvalid[1]),
        .mem_rdata_o(rdata[1]), .mem_err_o(err[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one request on responder d and wait for its response pulse.
    task automatic txn(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] m, output logic [31:0] rd, output logic e, output int lat);
        int g;
        @(negedge clk);
        req[d]   = 1'b1;
        we[d]    = w;
        raddr[d] = w ? 32'hFFFF_FFF0 : a;
        waddr[d] = w ? a : 32'h0000_0000;
        wdata[d] = wd;
        wmask[d] = m;
        g = 0;
        while (!gnt[d] && g < 20) begin
            @(negedge clk);
            g++;
        end
        if (!gnt[d]) check("gnt_timeout", 32'(gnt[d]), 32'd1);
        @(negedge clk);
        req[d] = 1'b0;
        we[d]  = 1'b0;
        lat = 1;
        while (!rvalid[d] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!rvalid[d]) check("rvalid_timeout", 32'(rvalid[d]), 32'd1);
        rd = rdata[d];
        e  = err[d];
        @(negedge clk);
        check($sformatf("pulse_width_d%0d", d), 32'(rvalid[d]), 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic        e;
        int          lat;
        logic        seen;

        for (int d = 0; d < 2; d++) begin
            req[d] = 1'b0; we[d] = 1'b0; raddr[d] = '0; waddr[d] = '0;
            wdata[d] = '0; wmask[d] = '0;
        end

        // Reset values
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_gnt_d%0d", d),    32'(gnt[d]),    32'd1);
            check($sformatf("rst_rvalid_d%0d", d), 32'(rvalid[d]), 32'd0);
            check($sformatf("rst_err_d%0d", d),    32'(err[d]),    32'd0);
            check($sformatf("rst_rdata_d%0d", d),  rdata[d],       32'd0);
        end
        rst_n = 1'b1;

        // Word store then load, zero wait states
        txn(0, 1'b1, 32'h1000_0010, 32'hDEAD_BEEF, 4'b1111, rd, e, lat);
        check("sw_lat", 32'(lat), 32'd1);
        check("sw_err", 32'(e), 32'd0);
        txn(0, 1'b0, 32'h1000_0010, 32'h0, 4'b0000, rd, e, lat);
        check("lw_lat", 32'(lat), 32'd1);
        check("lw_data", rd, 32'hDEAD_BEEF);
        check("lw_err", 32'(e), 32'd0);

        // Byte store into the top lane
        txn(0, 1'b1, 32'h1000_0010, 32'h1122_3344, 4'b1111, rd, e, lat);
        txn(0, 1'b1, 32'h1000_0013, 32'h5A00_0000, 4'b1000, rd, e, lat);
        txn(0, 1'b0, 32'h1000_0012, 32'h0, 4'b0000, rd, e, lat);
        check("sb_data", rd, 32'h5A22_3344);

        // Empty mask is an acknowledged no-op; rdata holds across a write
        txn(0, 1'b1, 32'h1000_0010, 32'hFFFF_FFFF, 4'b0000, rd, e, lat);
        check("nomask_err", 32'(e), 32'd0);
        check("rdata_hold", rdata[0], 32'h5A22_3344);
        txn(0, 1'b0, 32'h1000_0010, 32'h0, 4'b0000, rd, e, lat);
        check("nomask_data", rd, 32'h5A22_3344);

        // Legal upper halfword store
        txn(0, 1'b1, 32'h1000_0012, 32'h7766_0000, 4'b1100, rd, e, lat);
        check("sh2_err", 32'(e), 32'd0);
        txn(0, 1'b0, 32'h1000_0010, 32'h0, 4'b0000, rd, e, lat);
        check("sh2_data", rd, 32'h7766_3344);

        // Window boundaries
        txn(0, 1'b1, 32'h1000_0000, 32'hA5A5_A5A5, 4'b1111, rd, e, lat);
        txn(0, 1'b1, 32'h1000_3FFC, 32'hCAFE_F00D, 4'b1111, rd, e, lat);
        txn(0, 1'b0, 32'h1000_3FFC, 32'h0, 4'b0000, rd, e, lat);
        check("last_data", rd, 32'hCAFE_F00D);
        check("last_err", 32'(e), 32'd0);
        txn(0, 1'b0, 32'h0FFF_FFFC, 32'h0, 4'b0000, rd, e, lat);
        check("below_err", 32'(e), 32'd1);
        check("below_data", rd, 32'd0);
        txn(0, 1'b1, 32'h1000_4000, 32'hFFFF_FFFF, 4'b1111, rd, e, lat);
        check("above_wr_err", 32'(e), 32'd1);
        txn(0, 1'b0, 32'h1000_4000, 32'h0, 4'b0000, rd, e, lat);
        check("above_rd_err", 32'(e), 32'd1);
        check("above_rd_data", rd, 32'd0);
        txn(0, 1'b0, 32'h1000_0000, 32'h0, 4'b0000, rd, e, lat);
        check("word0_intact", rd, 32'hA5A5_A5A5);
        check("word0_err", 32'(e), 32'd0);

        // Three wait states
        txn(1, 1'b1, 32'h1000_0020, 32'h0102_0304, 4'b1111, rd, e, lat);
        check("w3_sw_lat", 32'(lat), 32'd4);

        // Reset while a store is waiting
        @(negedge clk);
        req[1] = 1'b1; we[1] = 1'b1; waddr[1] = 32'h1000_0020;
        wdata[1] = 32'h9999_9999; wmask[1] = 4'b1111;
        @(negedge clk);
        req[1] = 1'b0; we[1] = 1'b0;
        rst_n = 1'b0;
        seen = rvalid[1];
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            seen = seen | rvalid[1];
        end
        check("rst_mid_no_rvalid", 32'(seen), 32'd0);
        check("rst_mid_rdata", rdata[1], 32'd0);
        txn(1, 1'b0, 32'h1000_0020, 32'h0, 4'b0000, rd, e, lat);
        check("rst_mid_intact", rd, 32'h0102_0304);

        // Grant/response timing with a request held through the busy window
        @(negedge clk);
        req[1] = 1'b1; we[1] = 1'b0; raddr[1] = 32'h1000_0020;
        check("t4_gnt_c10", 32'(gnt[1]), 32'd1);
        for (int k = 11; k <= 14; k++) begin
            @(negedge clk);
            check($sformatf("t4_gnt_c%0d", k), 32'(gnt[1]), 32'd0);
            check($sformatf("t4_rvalid_c%0d", k), 32'(rvalid[1]), (k == 14) ? 32'd1 : 32'd0);
            if (k == 14) check("t4_rdata_c14", rdata[1], 32'h0102_0304);
        end
        @(negedge clk);
        check("t4_gnt_c15", 32'(gnt[1]), 32'd1);
        @(negedge clk);
        req[1] = 1'b0;
        lat = 1;
        while (!rvalid[1] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("t4_held_lat", 32'(lat), 32'd4);
        check("t4_held_data", rdata[1], 32'h0102_0304);

        // Halfword mask at an odd offset
        txn(1, 1'b1, 32'h1000_0021, 32'h00AA_BB00, 4'b0110, rd, e, lat);
        check("mis_err", 32'(e), MIS_EN ? 32'd1 : 32'd0);
        txn(1, 1'b0, 32'h1000_0020, 32'h0, 4'b0000, rd, e, lat);
        check("mis_data", rd, MIS_EN ? 32'h0102_0304 : 32'h01AA_BB04);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
